// File: rtl/in_channel_pkg.sv
// Shared types and default sizing for the input-channel feeder.
// Holds the channel state encoding and the channel word type.
package in_channel_pkg;

  localparam int DefaultMemoryElementWidth = 12;
  localparam int DefaultNIn                = 16;

  typedef logic [DefaultMemoryElementWidth-1:0] word_t;

  typedef enum logic [1:0] {
    OPEN     = 2'd0,
    DRAINING = 2'd1,
    CLOSED   = 2'd2
  } state_e;

endpackage

// File: rtl/in_channel_ram.sv
// Simple dual-port word store: synchronous write, registered read.
// The read register only loads on a read enable, so it holds across misses.
module in_channel_ram #(
  parameter int Width     = 12,
  parameter int Depth     = 16,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem_r [Depth];
  logic [Width-1:0] rdata_r;

  // write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // read register, cleared by reset
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rdata_r <= {Width{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/in_channel_feeder.sv
// Input-channel end of the in/inSize protocol: valid/ready writer side,
// one-cycle pop side for the `in` instruction, registered buffered count.
module in_channel_feeder
  import in_channel_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NIn                = DefaultNIn,
  parameter int PtrWidth           = $clog2(NIn)
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          inValid,
  input  logic [MemoryElementWidth-1:0] inData,
  output logic                          inReady,
  input  logic                          close,
  input  logic                          readReq,
  output logic                          readValid,
  output logic                          readHit,
  output logic [MemoryElementWidth-1:0] readData,
  output logic [MemoryElementWidth-1:0] inSize,
  output logic                          closed,
  output logic                          overflowSticky
);

  localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);
  localparam logic [PtrWidth:0]   CountOne  = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth:0]   CountZero = (PtrWidth + 1)'(0);
  localparam logic [PtrWidth:0]   CountFull = (PtrWidth + 1)'(NIn);

  logic [PtrWidth-1:0]           rd_ptr_r;
  logic [PtrWidth-1:0]           wr_ptr_r;
  logic [PtrWidth:0]             count_r;
  logic [PtrWidth:0]             count_next_s;
  state_e                        state_r;
  state_e                        state_next_s;
  logic                          push_s;
  logic                          pop_s;
  logic                          in_ready_r;
  logic                          read_valid_r;
  logic                          read_hit_r;
  logic                          closed_r;
  logic                          overflow_r;
  logic [MemoryElementWidth-1:0] in_size_r;

  // A pop needs a word already stored; a same-cycle push never bypasses.
  assign push_s = inValid && in_ready_r;
  assign pop_s  = readReq && (count_r != CountZero);

  // occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CountOne;
      2'b01:   count_next_s = count_r - CountOne;
      default: count_next_s = count_r;
    endcase
  end

  // channel lifecycle: closing an empty channel with no push skips DRAINING
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      OPEN: begin
        if (close) begin
          if ((count_r == CountZero) && !push_s) begin
            state_next_s = CLOSED;
          end else begin
            state_next_s = DRAINING;
          end
        end else begin
          state_next_s = OPEN;
        end
      end
      DRAINING: begin
        if (count_r == CountZero) begin
          state_next_s = CLOSED;
        end else begin
          state_next_s = DRAINING;
        end
      end
      CLOSED:  state_next_s = CLOSED;
      default: state_next_s = OPEN;
    endcase
  end

  // state, pointers and registered outputs
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r      <= OPEN;
      rd_ptr_r     <= {PtrWidth{1'b0}};
      wr_ptr_r     <= {PtrWidth{1'b0}};
      count_r      <= CountZero;
      in_ready_r   <= 1'b1;
      read_valid_r <= 1'b0;
      read_hit_r   <= 1'b0;
      closed_r     <= 1'b0;
      overflow_r   <= 1'b0;
      in_size_r    <= {MemoryElementWidth{1'b0}};
    end else begin
      state_r      <= state_next_s;
      count_r      <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end
      in_ready_r   <= (count_next_s < CountFull) && (state_next_s == OPEN);
      read_valid_r <= readReq;
      read_hit_r   <= pop_s;
      closed_r     <= (state_next_s == CLOSED);
      if (inValid && !in_ready_r) begin
        overflow_r <= 1'b1;
      end
      in_size_r    <= MemoryElementWidth'(count_next_s);
    end
  end

  in_channel_ram #(
    .Width     (MemoryElementWidth),
    .Depth     (NIn),
    .AddrWidth (PtrWidth)
  ) u_ram (
    .clock  (clock),
    .resetN (resetN),
    .we     (push_s),
    .waddr  (wr_ptr_r),
    .wdata  (inData),
    .re     (pop_s),
    .raddr  (rd_ptr_r),
    .rdata  (readData)
  );

  assign inReady        = in_ready_r;
  assign readValid      = read_valid_r;
  assign readHit        = read_hit_r;
  assign inSize         = in_size_r;
  assign closed         = closed_r;
  assign overflowSticky = overflow_r;

endmodule

// File: tb/tb_in_channel_feeder.sv
// Self-checking bench for in_channel_feeder: directed table, hand sequences,
// and randomized traffic against a queue-based channel model.
module tb_in_channel_feeder;

  localparam int W   = 12;
  localparam int NIN = 16;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         inValid = 1'b0;
  logic [W-1:0] inData = '0;
  logic         inReady;
  logic         close = 1'b0;
  logic         readReq = 1'b0;
  logic         readValid;
  logic         readHit;
  logic [W-1:0] readData;
  logic [W-1:0] inSize;
  logic         closed;
  logic         overflowSticky;

  in_channel_feeder dut (
    .clock          (clock),
    .resetN         (resetN),
    .inValid        (inValid),
    .inData         (inData),
    .inReady        (inReady),
    .close          (close),
    .readReq        (readReq),
    .readValid      (readValid),
    .readHit        (readHit),
    .readData       (readData),
    .inSize         (inSize),
    .closed         (closed),
    .overflowSticky (overflowSticky)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // channel model: a FIFO of words plus lifecycle flags
  int q[$];
  bit m_close_seen, m_closed, m_ovf, m_rv, m_hit, m_ready;
  int m_data, m_size;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_close_seen = 0; m_closed = 0; m_ovf = 0; m_rv = 0; m_hit = 0;
    m_ready = 1; m_data = 0; m_size = 0;
  endtask

  // apply the rules for one rising edge using the inputs present at that edge
  task automatic model_step();
    int sz;
    bit push, hit;
    sz   = q.size();
    push = inValid && m_ready;
    hit  = readReq && (sz > 0);
    if (inValid && !m_ready) m_ovf = 1;
    m_rv  = readReq;
    m_hit = hit;
    if (hit) m_data = q.pop_front();
    if (push) q.push_back(int'(inData));
    if (!m_closed) begin
      if (m_close_seen) m_closed = (sz == 0);
      else if (close)   m_closed = (sz == 0) && !push;
    end
    if (close) m_close_seen = 1;
    m_size  = q.size();
    m_ready = (q.size() < NIN) && !m_close_seen;
  endtask

  task automatic check_all();
    chk("inReady", 32'(inReady), 32'(m_ready));
    chk("readValid", 32'(readValid), 32'(m_rv));
    chk("readHit", 32'(readHit), 32'(m_hit));
    chk("readData", 32'(readData), 32'(m_data));
    chk("inSize", 32'(inSize), 32'(m_size));
    chk("closed", 32'(closed), 32'(m_closed));
    chk("overflowSticky", 32'(overflowSticky), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input int d, input bit c, input bit r);
    inValid = v; inData = W'(d); close = c; readReq = r;
  endtask

  // async reset assertion with immediate output check, release between edges
  task automatic do_reset();
    drive(0, 0, 0, 0);
    resetN = 1'b0;
    #2;
    chk("rst readValid", 32'(readValid), 32'd0);
    chk("rst readHit", 32'(readHit), 32'd0);
    chk("rst readData", 32'(readData), 32'd0);
    chk("rst inSize", 32'(inSize), 32'd0);
    chk("rst closed", 32'(closed), 32'd0);
    chk("rst overflowSticky", 32'(overflowSticky), 32'd0);
    model_reset();
    @(negedge clock);
    resetN = 1'b1;
    #1;
    check_all();
  endtask

  typedef struct {
    bit vld; int dat; bit cls; bit rr;
    int e_size; bit e_rv; bit e_hit; int e_data; bit e_ready; bit e_closed;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 88, 0, 0, 1, 0, 0, 0,  1, 0};
    tbl[1] = '{1, 44, 0, 0, 2, 0, 0, 0,  1, 0};
    tbl[2] = '{0, 0,  1, 0, 2, 0, 0, 0,  0, 0};
    tbl[3] = '{0, 0,  0, 0, 2, 0, 0, 0,  0, 0};
    tbl[4] = '{0, 0,  0, 1, 1, 1, 1, 88, 0, 0};
    tbl[5] = '{0, 0,  0, 0, 1, 0, 0, 88, 0, 0};
    tbl[6] = '{0, 0,  0, 1, 0, 1, 1, 44, 0, 0};
    tbl[7] = '{0, 0,  0, 0, 0, 0, 0, 44, 0, 1};
    tbl[8] = '{0, 0,  0, 1, 0, 1, 0, 44, 0, 1};

    #3;
    do_reset();

    // 88, 44, close, then alternating inSize checks and pops
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].vld, tbl[i].dat, tbl[i].cls, tbl[i].rr);
      tick();
      chk($sformatf("tbl%0d inSize", i), 32'(inSize), 32'(tbl[i].e_size));
      chk($sformatf("tbl%0d readValid", i), 32'(readValid), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d readHit", i), 32'(readHit), 32'(tbl[i].e_hit));
      chk($sformatf("tbl%0d readData", i), 32'(readData), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d inReady", i), 32'(inReady), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d closed", i), 32'(closed), 32'(tbl[i].e_closed));
    end

    // pop on empty while a push lands: miss, then the word on the next pop
    do_reset();
    drive(1, 12'h5A5, 0, 1);
    tick();
    chk("empty push readHit", 32'(readHit), 32'd0);
    chk("empty push readValid", 32'(readValid), 32'd1);
    drive(0, 0, 0, 1);
    tick();
    chk("after push readHit", 32'(readHit), 32'd1);
    chk("after push readData", 32'(readData), 32'h5A5);

    // steady stream: prefill 3, then push and pop together for 40 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 100 + i, 0, 0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, 103 + i, 0, 1);
      tick();
      chk("stream inSize", 32'(inSize), 32'd3);
      chk("stream readHit", 32'(readHit), 32'd1);
      chk("stream readData", 32'(readData), 32'(100 + i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      tick();
      chk("drain readData", 32'(readData), 32'(140 + i));
    end

    // fill across pointer wrap, overflow on the 17th, pop in order
    for (int i = 0; i < NIN; i++) begin
      drive(1, i, 0, 0);
      tick();
    end
    chk("full inReady", 32'(inReady), 32'd0);
    chk("full inSize", 32'(inSize), 32'd16);
    drive(1, 999, 0, 0);
    tick();
    chk("overflow sticky", 32'(overflowSticky), 32'd1);
    for (int i = 0; i < NIN; i++) begin
      drive(0, 0, 0, 1);
      tick();
      chk("wrap readHit", 32'(readHit), 32'd1);
      chk("wrap readData", 32'(readData), 32'(i));
    end
    drive(0, 0, 0, 0);
    tick();
    chk("refill inReady", 32'(inReady), 32'd1);

    // reset mid-stream with 5 words buffered
    for (int i = 0; i < 5; i++) begin
      drive(1, 300 + i, 0, 0);
      tick();
    end
    chk("pre-reset inSize", 32'(inSize), 32'd5);
    do_reset();
    chk("post-reset inSize", 32'(inSize), 32'd0);
    drive(0, 0, 0, 1);
    tick();
    chk("post-reset readHit", 32'(readHit), 32'd0);
    chk("post-reset readValid", 32'(readValid), 32'd1);

    // randomized traffic against the model, close near the end
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 4095)),
            (i > 300 && $urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0);
      tick();
    end
    for (int i = 0; i < 24; i++) begin
      drive(0, 0, (i == 0) ? 1'b1 : 1'b0, 1);
      tick();
    end
    chk("random end closed", 32'(closed), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
